// File: rtl/cpu24_pkg.sv
// ----------------------------------------------------------------------------
// cpu24_pkg
// Shared definitions for the 24-bit datapath blocks.
//   WORD_W      : native data word width
//   arb_state_e : state encoding of the two-requester round-robin arbiter
// ----------------------------------------------------------------------------
package cpu24_pkg;

    localparam int WORD_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage : cpu24_pkg

// File: rtl/out_stage_24bit.sv
// ----------------------------------------------------------------------------
// out_stage_24bit
// One-entry valid/ready output register. It selects the owner's word
// (sel_i ? req1_data_i : req0_data_i) and loads it when load_i is high.
// Otherwise it clears valid once the consumer takes the word, or holds.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_i          : a beat is accepted this cycle
//   sel_i           : current owner, picks the source word
//   req0_data_i     : requester 0 word
//   req1_data_i     : requester 1 word
//   out_ready_i     : consumer ready
//   out_valid_o     : buffered word present
//   out_data_o      : buffered word
// ----------------------------------------------------------------------------
module out_stage_24bit
    import cpu24_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             sel_i,
    input  logic [WIDTH-1:0] req0_data_i,
    input  logic [WIDTH-1:0] req1_data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = sel_i ? req1_data_i : req0_data_i;
        end else if (valid_q && out_ready_i) begin
            // Word taken and nothing new: drop valid, keep the last data visible.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule : out_stage_24bit

// File: rtl/arbiter2n1_24bit.sv
// ----------------------------------------------------------------------------
// arbiter2n1_24bit
// Round-robin arbiter sharing one 24-bit write path between two requesters.
// The grant is registered; the winning word is buffered in a one-entry
// valid/ready output stage. An owner keeps the grant for at most MAX_HOLD
// consecutive beats while the other requester waits.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req0_valid_i/data_i/ready_o : requester 0 handshake
//   req1_valid_i/data_i/ready_o : requester 1 handshake
//   out_valid_o/data_o/ready_i  : consumer handshake
//   sel_o                       : current owner (1 = requester 1)
//   busy_o                      : arbiter owns a requester (not IDLE)
// ----------------------------------------------------------------------------
module arbiter2n1_24bit
    import cpu24_pkg::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic             sel_o,
    output logic             busy_o
);

    localparam int              CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W:0]  HOLD_LIM = (CNT_W+1)'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_HOLD);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_grant_q, last_grant_d;
    logic             sel_q, sel_d;

    logic             own_is1;
    logic             own_valid;
    logic             oth_valid;
    logic             path_free;
    logic             accept;
    logic             hold_done;
    logic             out_valid;

    assign own_is1   = (state_q == OWN1);
    assign own_valid = own_is1 ? req1_valid_i : req0_valid_i;
    assign oth_valid = own_is1 ? req0_valid_i : req1_valid_i;
    assign path_free = !out_valid || out_ready_i;
    // ">=" rather than "==" so a count saturated during a solo run still
    // hands over as soon as the other requester shows up.
    assign hold_done = ({1'b0, count_q} + (CNT_W+1)'(1)) >= HOLD_LIM;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid_i && req1_valid_i) begin
                    state_d = last_grant_q ? OWN0 : OWN1;
                    sel_d   = !last_grant_q;
                end else if (req0_valid_i) begin
                    state_d = OWN0;
                    sel_d   = 1'b0;
                end else if (req1_valid_i) begin
                    state_d = OWN1;
                    sel_d   = 1'b1;
                end
            end
            OWN0, OWN1: begin
                req0_ready_o = !own_is1 && path_free;
                req1_ready_o =  own_is1 && path_free;
                accept       = own_valid && path_free;
                if ((accept && oth_valid && hold_done) || (!own_valid && oth_valid)) begin
                    state_d      = own_is1 ? OWN0 : OWN1;
                    sel_d        = !own_is1;
                    last_grant_d = own_is1;
                    count_d      = '0;
                end else if (!own_valid) begin
                    // Nobody requesting: go idle, Sel keeps its last value.
                    state_d      = IDLE;
                    last_grant_d = own_is1;
                    count_d      = '0;
                end else if (accept && (count_q != CNT_SAT)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
        end
    end

    out_stage_24bit #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .sel_i       (sel_q),
        .req0_data_i (req0_data_i),
        .req1_data_i (req1_data_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid),
        .out_data_o  (out_data_o)
    );

    assign out_valid_o = out_valid;
    assign sel_o       = sel_q;
    assign busy_o      = (state_q != IDLE);

endmodule : arbiter2n1_24bit

// File: tb/tb_arbiter2n1_24bit.sv
// ----------------------------------------------------------------------------
// tb_arbiter2n1_24bit
// Directed vector table for arbiter2n1_24bit (MAX_HOLD=4) plus hand-written
// sequences for the output stall and the mid-burst owner switch.
// ----------------------------------------------------------------------------
module tb_arbiter2n1_24bit;

    logic        clk;
    logic        rst_n;
    logic        req0_valid_i, req1_valid_i;
    logic [23:0] req0_data_i, req1_data_i;
    logic        req0_ready_o, req1_ready_o;
    logic        out_valid_o;
    logic [23:0] out_data_o;
    logic        out_ready_i;
    logic        sel_o, busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    arbiter2n1_24bit #(.WIDTH(24), .MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_ready_o (req1_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .sel_o        (sel_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        r0v;
        logic [23:0] r0d;
        logic        r1v;
        logic [23:0] r1d;
        logic        ordy;
        logic        eov;
        logic [23:0] edata;
        logic        esel;
        logic        ebusy;
        logic        er0r;
        logic        er1r;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rn, input logic r0v, input logic [23:0] r0d,
                                input logic r1v, input logic [23:0] r1d, input logic ordy,
                                input logic eov, input logic [23:0] edata, input logic esel,
                                input logic ebusy, input logic er0r, input logic er1r);
        vec_t v;
        v.rst_n = rn;  v.r0v = r0v;  v.r0d = r0d;  v.r1v = r1v;  v.r1d = r1d;
        v.ordy = ordy; v.eov = eov;  v.edata = edata; v.esel = esel;
        v.ebusy = ebusy; v.er0r = er0r; v.er1r = er1r;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [23:0] act,
                         input logic [23:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("out_valid", idx, {23'd0, out_valid_o},  {23'd0, v.eov});
        check("out_data",  idx, out_data_o,            v.edata);
        check("sel",       idx, {23'd0, sel_o},        {23'd0, v.esel});
        check("busy",      idx, {23'd0, busy_o},       {23'd0, v.ebusy});
        check("req0_ready",idx, {23'd0, req0_ready_o}, {23'd0, v.er0r});
        check("req1_ready",idx, {23'd0, req1_ready_o}, {23'd0, v.er1r});
    endtask

    int r0_beats;
    logic acc;
    logic switched;

    initial begin
        //             rst r0v r0d        r1v r1d        ordy| ov data       sel bsy r0r r1r
        vecs[0]  = mk(0, 0, 24'h000000, 0, 24'h000000, 0,  0, 24'h000000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 24'h000001, 0, 24'h000000, 1,  0, 24'h000000, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 24'h000001, 0, 24'h000000, 1,  0, 24'h000000, 0, 1, 1, 0);
        vecs[3]  = mk(1, 1, 24'h000002, 0, 24'h000000, 1,  1, 24'h000001, 0, 1, 1, 0);
        vecs[4]  = mk(1, 1, 24'h000003, 0, 24'h000000, 1,  1, 24'h000002, 0, 1, 1, 0);
        vecs[5]  = mk(1, 1, 24'h000004, 0, 24'h000000, 1,  1, 24'h000003, 0, 1, 1, 0);
        vecs[6]  = mk(1, 1, 24'h000005, 0, 24'h000000, 1,  1, 24'h000004, 0, 1, 1, 0);
        vecs[7]  = mk(1, 1, 24'h000006, 1, 24'h100001, 1,  1, 24'h000005, 0, 1, 1, 0);
        vecs[8]  = mk(1, 1, 24'h000007, 1, 24'h100001, 1,  1, 24'h000006, 1, 1, 0, 1);
        vecs[9]  = mk(1, 1, 24'h000007, 1, 24'h100002, 1,  1, 24'h100001, 1, 1, 0, 1);
        vecs[10] = mk(1, 1, 24'h000007, 1, 24'h100003, 1,  1, 24'h100002, 1, 1, 0, 1);
        vecs[11] = mk(1, 1, 24'h000007, 1, 24'h100004, 1,  1, 24'h100003, 1, 1, 0, 1);
        vecs[12] = mk(1, 1, 24'h000007, 1, 24'h100005, 1,  1, 24'h100004, 0, 1, 1, 0);
        vecs[13] = mk(1, 0, 24'h000008, 1, 24'h100005, 1,  1, 24'h000007, 0, 1, 1, 0);
        vecs[14] = mk(1, 0, 24'h000008, 1, 24'h100005, 0,  0, 24'h000007, 1, 1, 0, 1);
        vecs[15] = mk(1, 0, 24'h000008, 1, 24'h100006, 0,  1, 24'h100005, 1, 1, 0, 0);
        vecs[16] = mk(1, 0, 24'h000008, 1, 24'h100006, 0,  1, 24'h100005, 1, 1, 0, 0);
        vecs[17] = mk(1, 0, 24'h000008, 1, 24'h100006, 1,  1, 24'h100005, 1, 1, 0, 1);
        vecs[18] = mk(1, 0, 24'h000008, 0, 24'h100007, 0,  1, 24'h100006, 1, 1, 0, 0);
        vecs[19] = mk(1, 0, 24'h000008, 0, 24'h100007, 0,  1, 24'h100006, 1, 0, 0, 0);
        vecs[20] = mk(1, 0, 24'h000008, 0, 24'h100007, 1,  1, 24'h100006, 1, 0, 0, 0);
        vecs[21] = mk(1, 0, 24'h000008, 0, 24'h100007, 1,  0, 24'h100006, 1, 0, 0, 0);
        vecs[22] = mk(1, 1, 24'h000008, 1, 24'h100007, 1,  0, 24'h100006, 1, 0, 0, 0);
        vecs[23] = mk(1, 1, 24'h000008, 1, 24'h100007, 1,  0, 24'h100006, 0, 1, 1, 0);
        vecs[24] = mk(1, 1, 24'h000009, 1, 24'h100007, 1,  1, 24'h000008, 0, 1, 1, 0);
        vecs[25] = mk(0, 1, 24'h00000A, 1, 24'h100007, 1,  0, 24'h000000, 0, 0, 0, 0);
        vecs[26] = mk(1, 1, 24'h00000A, 1, 24'h100007, 1,  0, 24'h000000, 0, 0, 0, 0);
        vecs[27] = mk(1, 1, 24'h00000A, 1, 24'h100007, 1,  0, 24'h000000, 0, 1, 1, 0);

        rst_n = 1'b0;
        req0_valid_i = 1'b0; req0_data_i = '0;
        req1_valid_i = 1'b0; req1_data_i = '0;
        out_ready_i  = 1'b0;

        // Table: inputs driven after the falling edge, outputs sampled 1 ns later.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n        = vecs[i].rst_n;
            req0_valid_i = vecs[i].r0v;
            req0_data_i  = vecs[i].r0d;
            req1_valid_i = vecs[i].r1v;
            req1_data_i  = vecs[i].r1d;
            out_ready_i  = vecs[i].ordy;
            #1;
            check_all(i, vecs[i]);
            $display("[TB] vec %0d: ov=%0b data=%h sel=%0b busy=%0b r0rdy=%0b r1rdy=%0b",
                     i, out_valid_o, out_data_o, sel_o, busy_o, req0_ready_o, req1_ready_o);
        end

        // Stall sequence: requester 1 alone delivers ABCDEF, consumer stalls 3 cycles.
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; out_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req1_valid_i = 1'b1; req1_data_i = 24'hABCDEF;
        @(negedge clk);                       // OWN1, path free
        #1;
        check("stall_sel",  100, {23'd0, sel_o},        24'd1);
        check("stall_r1rdy",100, {23'd0, req1_ready_o}, 24'd1);
        @(negedge clk);                       // ABCDEF accepted at the edge
        req1_data_i = 24'h123456;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("stall_ov",    101 + k, {23'd0, out_valid_o},  24'd1);
            check("stall_data",  101 + k, out_data_o,            24'hABCDEF);
            check("stall_r1rdy", 101 + k, {23'd0, req1_ready_o}, 24'd0);
            $display("[TB] stall %0d: ov=%0b data=%h r1rdy=%0b", k, out_valid_o, out_data_o, req1_ready_o);
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        #1;
        check("release_r1rdy", 104, {23'd0, req1_ready_o}, 24'd1);
        @(negedge clk);                       // 123456 accepted on release
        #1;
        check("release_data", 105, out_data_o, 24'h123456);
        check("release_ov",   105, {23'd0, out_valid_o}, 24'd1);
        $display("[TB] release: ov=%0b data=%h", out_valid_o, out_data_o);

        // Requester 1 drops while requester 0 waits -> OWN0 with a fresh count:
        // requester 0 must get exactly MAX_HOLD beats once requester 1 returns.
        req1_valid_i = 1'b0;
        req0_valid_i = 1'b1; req0_data_i = 24'h0000A0;
        @(negedge clk);
        #1;
        check("switch_sel",   106, {23'd0, sel_o},        24'd0);
        check("switch_r0rdy", 106, {23'd0, req0_ready_o}, 24'd1);
        req1_valid_i = 1'b1; req1_data_i = 24'h654321;
        r0_beats = 0;
        switched = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sel_o) begin
                switched = 1'b1;
                break;
            end
            acc = req0_valid_i && req0_ready_o;
            if (acc) r0_beats++;
            @(negedge clk);
            if (acc) req0_data_i = req0_data_i + 24'd1;
            #1;
        end
        if (!switched) begin
            tests_run++;
            tests_failed++;
            $display("FAIL switch_timeout: sel never returned to 1 within 20 cycles");
        end
        check("burst_beats", 107, 24'(r0_beats), 24'd4);
        check("burst_next",  107, req0_data_i,   24'h0000A4);
        check("burst_last",  107, out_data_o,    24'h0000A3);
        $display("[TB] burst: r0 beats=%0d last out=%h", r0_beats, out_data_o);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_arbiter2n1_24bit
